// File: rtl/perf_monitor_if.sv
// rtl/perf_monitor_if.sv - registered counter readout port for perf_monitor
interface perf_monitor_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 32
) ();
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [CNT_W-1:0]  o_rd_data;
  logic              o_rd_valid;
  logic              o_rd_err;

  modport master (output i_rd_en, i_rd_addr, input o_rd_data, o_rd_valid, o_rd_err);
  modport slave  (input i_rd_en, i_rd_addr, output o_rd_data, o_rd_valid, o_rd_err);
endinterface

// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - saturating occupancy/usage counters with run control and readout
module perf_monitor #(
  parameter int PROC_COUNT  = 4,
  parameter int PROC_STATES = 11,
  parameter int STATE_W     = 5,
  parameter int ISS_STATES  = 8,
  parameter int ISS_STATE_W = 4,
  parameter int CNT_W       = 32,
  parameter int ADDR_W      = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_clear,
  input  logic                          i_finished_task,
  input  logic                          i_queue_empty,
  input  logic [PROC_COUNT*STATE_W-1:0] i_proc_states,
  input  logic [ISS_STATE_W-1:0]        i_issuer_state,
  input  logic                          i_cmd_get,
  input  logic                          i_cmd_source,
  perf_monitor_if.slave                 rd,
  output logic                          o_running,
  output logic                          o_done,
  output logic                          o_bad_state
);
  localparam int BASE_I = 1 + PROC_COUNT * PROC_STATES;
  localparam int BASE_S = BASE_I + ISS_STATES;
  localparam int N_CNT  = BASE_S + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;
  state_t state;

  logic [CNT_W-1:0] cnt [N_CNT];
  logic [N_CNT-1:0] inc;
  logic             bad;
  logic             stop_cond;
  logic             count_en;
  logic [CNT_W-1:0] rd_mux;
  logic             rd_in_range;

  assign stop_cond = i_stop | (i_finished_task & i_queue_empty);
  assign count_en  = (state == S_RUN) && !stop_cond;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      o_running <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_RUN: begin
          if (stop_cond) begin
            state     <= S_HOLD;
            o_running <= 1'b0;
            o_done    <= 1'b1;
          end
        end
        default: begin
          if (i_start) begin
            state     <= S_RUN;
            o_running <= 1'b1;
          end
        end
      endcase
    end
  end

  // One increment bit per counter; out-of-range codes only raise bad
  always_comb begin
    inc = '0;
    bad = 1'b0;
    if (count_en) begin
      inc[0] = 1'b1;
      for (int p = 0; p < PROC_COUNT; p++) begin
        for (int s = 0; s < PROC_STATES; s++) begin
          if (i_proc_states[p*STATE_W +: STATE_W] == STATE_W'(s))
            inc[1 + p*PROC_STATES + s] = 1'b1;
        end
        if (int'(i_proc_states[p*STATE_W +: STATE_W]) >= PROC_STATES)
          bad = 1'b1;
      end
      for (int k = 0; k < ISS_STATES; k++) begin
        if (i_issuer_state == ISS_STATE_W'(k))
          inc[BASE_I + k] = 1'b1;
      end
      if (int'(i_issuer_state) >= ISS_STATES)
        bad = 1'b1;
      inc[BASE_S]     = i_cmd_get & ~i_cmd_source;
      inc[BASE_S + 1] = i_cmd_get &  i_cmd_source;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < N_CNT; i++) cnt[i] <= '0;
      o_bad_state <= 1'b0;
    end else if (i_clear) begin
      for (int i = 0; i < N_CNT; i++) cnt[i] <= '0;
      o_bad_state <= 1'b0;
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        if (inc[i] && (cnt[i] != {CNT_W{1'b1}}))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
      if (bad) o_bad_state <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (rd.i_rd_addr == ADDR_W'(i)) rd_mux = cnt[i];
    end
  end

  assign rd_in_range = int'(rd.i_rd_addr) < N_CNT;

  // Data holds between reads; valid/err are single-cycle
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd.o_rd_data  <= '0;
      rd.o_rd_valid <= 1'b0;
      rd.o_rd_err   <= 1'b0;
    end else if (rd.i_rd_en) begin
      rd.o_rd_valid <= 1'b1;
      rd.o_rd_err   <= !rd_in_range;
      rd.o_rd_data  <= rd_in_range ? rd_mux : '0;
    end else begin
      rd.o_rd_valid <= 1'b0;
      rd.o_rd_err   <= 1'b0;
    end
  end
endmodule
